// File: rtl/alu_share_ctrl.sv
// Round-robin shared controller for a 4-bit add/sub/and/or ALU.
// Two requesters, one response channel; one operation in flight at a time.
module alu_share_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Handshake rule for every channel here: a transfer happens on the rising
  // edge where valid && ready are both high; valid never waits on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             grant0, grant1;
  logic             hs0, hs1;
  logic [WIDTH:0]   alu_wide;

  // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = (state_q == S_IDLE) && grant0;
  assign req1_ready = (state_q == S_IDLE) && grant1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign op_count   = count_q;

  // Subtract is a + ~b + 1, so carry out high means no borrow.
  always_comb begin
    alu_wide = '0;
    case (op_q)
      OP_ADD:  alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_wide = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
      OP_AND:  alu_wide = {1'b0, a_q & b_q};
      default: alu_wide = {1'b0, a_q | b_q};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    count_d      = count_q;
    case (state_q)
      S_IDLE: begin
        if (hs0) begin
          op_d    = req0_op;
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = S_EXEC;
        end else if (hs1) begin
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_id_d     = id_q;
        rsp_result_d = alu_wide[WIDTH-1:0];
        rsp_carry_d  = (op_q == OP_ADD || op_q == OP_SUB) ? alu_wide[WIDTH] : 1'b0;
        rsp_zero_d   = (alu_wide[WIDTH-1:0] == '0);
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          count_d = count_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      count_q      <= count_d;
    end
  end

  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_result) && $stable(rsp_id)));

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table plus hand-written
// stall, reset-in-flight, alternation and counter-wrap sequences.
module tb_alu_share_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry, rsp_zero, busy;
  logic [CNT_W-1:0] op_count;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] exp_count = '0;

  typedef struct {
    logic             rid;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             zero;
  } vec_t;

  vec_t vecs[10];

  alu_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rsp_result"}, {28'd0, rsp_result}, 32'd0);
    check({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
    check({tag, "_rsp_carry"}, {31'd0, rsp_carry}, 32'd0);
    check({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
    check({tag, "_op_count"}, {24'd0, op_count}, 32'd0);
  endtask

  // driver: one operation from requester v.rid, response taken immediately
  task automatic run_op(input vec_t v, input bit full);
    int n;
    @(negedge clk);
    req0_a = WIDTH'($urandom_range(0, 15));
    req1_a = WIDTH'($urandom_range(0, 15));
    if (v.rid == 1'b0) begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end
    #1;
    n = 0;
    while (!(v.rid ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (full) check("ready_seen", {31'd0, (n < 20)}, 32'd1);
    if (full) check("other_ready_low", {31'd0, (v.rid ? req0_ready : req1_ready)}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req1_b = ~req1_b;
    if (full) begin
      check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("exec_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_id", {31'd0, rsp_id}, {31'd0, v.rid});
    check("rsp_result", {28'd0, rsp_result}, {28'd0, v.res});
    check("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.carry});
    check("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.zero});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    if (full) begin
      check("op_count", {24'd0, op_count}, {24'd0, exp_count});
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rsp_result_held", {28'd0, rsp_result}, {28'd0, v.res});
    end
  endtask

  initial begin
    int n;
    vec_t sv;
    vecs[0] = '{1'b0, 2'd0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'd2, 4'h5, 4'hA, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 2'd3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 2'd1, 4'h7, 4'h7, 4'h0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 2'd3, 4'h9, 4'h6, 4'hF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 2'd0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 2'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    #12;
    check_idle_zero("reset");
    check("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 10; i++) run_op(vecs[i], 1'b1);

    // stall in RESP for 5 cycles with requester 1 waiting
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'd1; req0_a = 4'h2; req0_b = 4'h9;
    #1;
    check("stall_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'd0; req1_a = 4'h1; req1_b = 4'h1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_result", {28'd0, rsp_result}, 32'h9);
      check("stall_carry", {31'd0, rsp_carry}, 32'd0);
      check("stall_id", {31'd0, rsp_id}, 32'd0);
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("stall_op_count", {24'd0, op_count}, {24'd0, exp_count});
      req1_a = WIDTH'($urandom_range(0, 15));
      @(negedge clk);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check("stall_op_count_after", {24'd0, op_count}, {24'd0, exp_count});

    // reset during EXEC drops the transaction
    req0_valid = 1'b1; req0_op = 2'd0; req0_a = 4'h9; req0_b = 4'h8;
    #1;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("rst_in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) n++;
    end
    check("midrst_no_rsp", n, 0);

    // both valid continuously: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_op = 2'd2; req0_a = 4'hC; req0_b = 4'hA;
    req1_valid = 1'b1; req1_op = 2'd3; req1_a = 4'h0; req1_b = 4'h0;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin @(negedge clk); #1; n++; end
      check("alt_req0_ready", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_req1_ready", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!rsp_valid && n < 10);
      check("alt_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("alt_id", {31'd0, rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check("alt_result", {28'd0, rsp_result}, (k % 2 == 0) ? 32'h8 : 32'h0);
      check("alt_zero", {31'd0, rsp_zero}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check("alt_carry", {31'd0, rsp_carry}, 32'd0);
      exp_count = exp_count + 1'b1;
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("alt_op_count", {24'd0, op_count}, {24'd0, exp_count});

    // 256 back-to-back ops from a fresh reset: counter wraps to 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    sv = '{1'b0, 2'd2, 4'h5, 4'hA, 4'h0, 1'b0, 1'b1};
    for (int k = 0; k < 256; k++) begin
      sv.rid = k[0];
      run_op(sv, (k >= 254) ? 1'b1 : 1'b0);
    end
    check("wrap_op_count", {24'd0, op_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
